// File: rtl/seq_detect_ctrl.sv
// Bit-serial pattern detection run controller: programmable pattern, match counting, timeout/abort.
// Latency: match/match_count update one cycle after the accepting clock edge; done follows target by one cycle.
// Backpressure: none; bit_valid-qualified bits are consumed every RUN cycle, and ignored outside RUN.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MAX_LEN-1:0]       cfg_pattern,
  input  logic [$clog2(MAX_LEN):0] cfg_len,
  input  logic                     cfg_overlap,
  input  logic [CNT_W-1:0]         cfg_target,
  input  logic [TMO_W-1:0]         cfg_timeout,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     bit_valid,
  input  logic                     bit_in,
  output logic                     busy,
  output logic                     match,
  output logic [CNT_W-1:0]         match_count,
  output logic                     done,
  output logic                     timed_out,
  output logic                     err_cfg
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [MAX_LEN-1:0] r_pattern, r_hist;
  logic [LEN_W-1:0]   r_len, r_fill;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_target, r_count;
  logic [TMO_W-1:0]   r_tmo, r_timer;
  logic               r_match, r_timed_out, r_err;

  logic               w_start_ok, w_run, w_at_target, w_accept, w_hit, w_tmo_hit;
  logic [MAX_LEN-1:0] w_hist_nxt, w_mask;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [TMO_W-1:0]   w_timer_inc;

  // Start is legal only for a length in 1..MAX_LEN and a non-zero target.
  assign w_start_ok  = start && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN)) && (cfg_target != '0);
  assign w_run       = (r_state == S_RUN);
  // Once the target is reached the run is over: further bits and timer ticks are ignored.
  assign w_at_target = (r_count == r_target);
  assign w_accept    = w_run && bit_valid && !abort && !w_at_target;
  assign w_hist_nxt  = {r_hist[MAX_LEN-2:0], bit_in};
  assign w_fill_inc  = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_fill;
  assign w_hit       = w_accept && (w_fill_inc == r_len) && (((w_hist_nxt ^ r_pattern) & w_mask) == '0);
  assign w_timer_inc = r_timer + TMO_W'(1);
  // A match in the same cycle clears the timer, so a final match always beats a timeout.
  assign w_tmo_hit   = w_run && !abort && !w_at_target && !w_hit && (r_tmo != '0) && (w_timer_inc == r_tmo);

  // Compare mask selecting the low r_len bits of history and pattern.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: abort beats completion; target completion beats timeout; DONE lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort)            w_state_nxt = S_IDLE;
        else if (w_at_target) w_state_nxt = S_DONE;
        else if (w_tmo_hit)   w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Config latch, shift history, fill, timer, match counting and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern   <= '0;
      r_len       <= '0;
      r_overlap   <= 1'b0;
      r_target    <= '0;
      r_tmo       <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_timer     <= '0;
      r_count     <= '0;
      r_match     <= 1'b0;
      r_timed_out <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_match <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == S_IDLE && start) begin
        if (w_start_ok) begin
          r_pattern   <= cfg_pattern;
          r_len       <= cfg_len;
          r_overlap   <= cfg_overlap;
          r_target    <= cfg_target;
          r_tmo       <= cfg_timeout;
          r_hist      <= '0;
          r_fill      <= '0;
          r_timer     <= '0;
          r_count     <= '0;
          r_timed_out <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end else if (w_run && !abort && !w_at_target) begin
        if (w_accept) begin
          r_hist <= w_hist_nxt;
          // Non-overlapping mode restarts the fill so matched bits are not reused.
          r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
        end
        if (w_hit) begin
          r_match <= 1'b1;
          r_timer <= '0;
          if (r_count != '1) r_count <= r_count + CNT_W'(1);
        end else begin
          r_timer <= w_timer_inc;
          if (w_tmo_hit) r_timed_out <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign match       = r_match;
  assign match_count = r_count;
  assign timed_out   = r_timed_out;
  assign err_cfg     = r_err;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic [7:0] cfg_target;
  logic [15:0] cfg_timeout;
  logic       start, abort, bit_valid, bit_in;
  logic       busy, match, done, timed_out, err_cfg;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TMO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(busy), .match(match), .match_count(match_count), .done(done),
    .timed_out(timed_out), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                          input logic [7:0] tgt, input logic [15:0] tmo);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt; cfg_timeout = tmo;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; bit_in = b;
    step();
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, match, done, timed_out, err_cfg, match_count} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b match=%b done=%b to=%b err=%b cnt=%0d, want all 0",
               busy, match, done, timed_out, err_cfg, match_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_overlap();
    logic [4:0] e = 5'b11100;  // e[i]: match expected after bit i+1
    int cnt = 0;
    do_start(8'b0000_0111, 4'd3, 1'b1, 8'd3, 16'd0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ovl_busy: got %b want 1", busy); end
    // Later cfg changes must not affect the running detector.
    cfg_len = 4'd1; cfg_pattern = 8'hFF; cfg_target = 8'd1;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1);
      if (e[i]) cnt++;
      n_checks++;
      if (match !== e[i] || match_count !== 8'(cnt)) begin
        n_fail++;
        $display("FAIL ovl_bit%0d: got match=%b cnt=%0d want match=%b cnt=%0d", i + 1, match, match_count, e[i], cnt);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || match !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ovl_done: got done=%b busy=%b match=%b to=%b want 1 0 0 0", done, busy, match, timed_out);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || match_count !== 8'd3) begin
      n_fail++;
      $display("FAIL ovl_after: got done=%b cnt=%0d want done=0 cnt=3", done, match_count);
    end
  endtask

  task automatic test_nonoverlap();
    logic [5:0] e = 6'b100100;
    do_start(8'b0000_0111, 4'd3, 1'b0, 8'd2, 16'd0);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (match !== e[i]) begin
        n_fail++;
        $display("FAIL novl_bit%0d: got match=%b want %b", i + 1, match, e[i]);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || match_count !== 8'd2) begin
      n_fail++;
      $display("FAIL novl_done: got done=%b cnt=%0d want done=1 cnt=2", done, match_count);
    end
  endtask

  task automatic test_101(input bit gaps);
    logic [4:0] b = 5'b10101;
    logic [4:0] e = 5'b10100;
    do_start(8'b0000_0101, 4'd3, 1'b1, 8'd2, 16'd0);
    for (int i = 0; i < 5; i++) begin
      send_bit(b[4-i]);
      n_checks++;
      if (match !== e[i]) begin
        n_fail++;
        $display("FAIL p101_gap%0d_bit%0d: got match=%b want %b", gaps, i + 1, match, e[i]);
      end
      if (gaps && i < 4) begin
        step();
        n_checks++;
        if (match !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL p101_gapcycle%0d: got match=%b busy=%b want 0 1", i + 1, match, busy);
        end
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || match_count !== 8'd2) begin
      n_fail++;
      $display("FAIL p101_gap%0d_done: got done=%b cnt=%0d want done=1 cnt=2", gaps, done, match_count);
    end
    step();
  endtask

  task automatic test_timeout();
    do_start(8'b0000_0111, 4'd3, 1'b1, 8'd4, 16'd5);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    n_checks++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_match: got match=%b cnt=%0d want 1 1", match, match_count);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (done !== (k == 5) || busy !== (k != 5) || timed_out !== (k == 5)) begin
        n_fail++;
        $display("FAIL tmo_cycle%0d: got done=%b busy=%b to=%b want %b %b %b", k, done, busy, timed_out,
                 k == 5, k != 5, k == 5);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b0 || timed_out !== 1'b1 || match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_hold: got done=%b to=%b cnt=%0d want 0 1 1", done, timed_out, match_count);
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] lens [3] = '{4'd0, 4'd9, 4'd3};
    logic [7:0] tgts [3] = '{8'd1, 8'd1, 8'd0};
    for (int i = 0; i < 3; i++) begin
      do_start(8'b0000_0111, lens[i], 1'b1, tgts[i], 16'd0);
      n_checks++;
      if (err_cfg !== 1'b1 || busy !== 1'b0 || timed_out !== 1'b1 || match_count !== 8'd1) begin
        n_fail++;
        $display("FAIL cfgerr%0d: got err=%b busy=%b to=%b cnt=%0d want 1 0 1 1", i, err_cfg, busy, timed_out, match_count);
      end
      step();
      n_checks++;
      if (err_cfg !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfgerr%0d_pulse: got err=%b busy=%b want 0 0", i, err_cfg, busy);
      end
    end
  endtask

  task automatic test_abort();
    do_start(8'b0000_0111, 4'd3, 1'b1, 8'd1, 16'd0);
    n_checks++;
    if (busy !== 1'b1 || timed_out !== 1'b0 || match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_start: got busy=%b to=%b cnt=%0d want 1 0 0", busy, timed_out, match_count);
    end
    send_bit(1'b1); send_bit(1'b1);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    n_checks++;
    if (match !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_cut: got match=%b busy=%b done=%b cnt=%0d want 0 0 0 0", match, busy, done, match_count);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_nodone: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_midrun();
    do_start(8'b0000_0111, 4'd3, 1'b1, 8'd5, 16'd0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    n_checks++;
    if (match_count !== 8'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got cnt=%0d busy=%b want 2 1", match_count, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, match, done, timed_out, err_cfg, match_count} !== 13'd0) begin
      n_fail++;
      $display("FAIL rst_mid: got busy=%b match=%b done=%b to=%b err=%b cnt=%0d want all 0",
               busy, match, done, timed_out, err_cfg, match_count);
    end
    #2 rst_n = 1'b1;
    step();
    do_start(8'b0000_0111, 4'd3, 1'b1, 8'd1, 16'd0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    n_checks++;
    if (match !== 1'b1 || match_count !== 8'd1) begin
      n_fail++;
      $display("FAIL rst_rerun: got match=%b cnt=%0d want 1 1", match, match_count);
    end
    step();
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rst_rerun_done: got %b want 1", done); end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0; cfg_timeout = '0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    test_reset();
    test_overlap();
    step();
    test_nonoverlap();
    step();
    test_101(1'b0);
    test_101(1'b1);
    test_timeout();
    test_cfg_err();
    test_abort();
    test_reset_midrun();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run controller for bit-serial pattern detection. It latches a programmable pattern of 1..MAX_LEN bits and arms detection on start. It then counts overlapping or non-overlapping matches on a valid-qualified serial bit stream. A run ends on a target match count, an idle timeout, or an abort, and the block reports status to a host/sequencer.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of match counter and target
TMO_W, 16, width of timeout counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 = first bit received, bit 0 = last
cfg_len  input  $clog2(MAX_LEN)+1  pattern length, legal 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  matches required to finish, legal >=1
cfg_timeout  input  TMO_W  max RUN cycles without a match; 0 = disabled
start  input  1  one-cycle pulse, starts a run from IDLE
abort  input  1  cancels a run
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial data bit
busy  output  1  high in RUN
match  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  matches in current/last run
done  output  1  one-cycle pulse when a run completes (target or timeout)
timed_out  output  1  last run ended by timeout; sticky until next start
err_cfg  output  1  one-cycle pulse: start rejected for illegal cfg

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; history, fill, timer and latched cfg cleared.
- States: IDLE, RUN, DONE.
- IDLE + start:
  - cfg_len in 1..MAX_LEN and cfg_target != 0: latch all cfg_*; clear history, fill, timer, match_count, timed_out; enter RUN next cycle (busy=1 from that cycle).
  - Otherwise: err_cfg=1 for one cycle, stay IDLE, match_count/timed_out unchanged.
- start while in RUN or DONE is ignored. cfg_* changes after start have no effect.
- RUN, bit accept (bit_valid=1, abort=0):
  - hist <= {hist[MAX_LEN-2:0], bit_in}.
  - fill <= min(fill+1, len).
  - Match when updated fill == len and updated hist[len-1:0] == pattern[len-1:0].
  - On match: match=1 and match_count+1 in the cycle after the accepting edge; 1-cycle latency from the bit edge.
  - cfg_overlap=0: fill resets to 0 on match, so matched bits are not reused. cfg_overlap=1: fill is retained.
- Timer:
  - Cleared at start and on every match; increments every RUN cycle with no match.
  - When cfg_timeout != 0 and timer reaches cfg_timeout: timed_out=1 and go to DONE.
- Target: when match_count reaches cfg_target, go to DONE. Bits arriving after that are ignored.
- Same cycle final match and timeout: match wins; timed_out=0, match_count=target.
- DONE lasts exactly 1 cycle: done=1, busy=0, then IDLE. match_count and timed_out hold until the next accepted start.
- abort in RUN: IDLE next cycle; no done, no match. A bit_valid in the same cycle is discarded. match_count holds. abort in IDLE/DONE has no effect.
- bit_valid outside RUN is ignored.
- match_count saturates at all-ones; reachable only via target = all-ones.
- rst_n asserted mid-run: immediate IDLE, all outputs 0.

Test Plan:
- Overlapping: pattern=3'b111, len=3, overlap=1, target=3. Bits 1,1,1,1,1 -> match pulses after bits 3,4,5; match_count=3; done 1 cycle after third match; busy falls; timed_out=0.
- Non-overlapping: same pattern, overlap=0, target=2. Bits 1,1,1,1,1,1 -> matches after bits 3 and 6 only; done; match_count=2.
- 101 overlapping: pattern=3'b101, len=3, target=2. Bits 1,0,1,0,1 -> matches after bits 3 and 5. Bits with gaps in bit_valid give identical results.
- Timeout: timeout=5, target=4, pattern 111. Bits 1,1,1, then bit_valid=0 -> one match, then timed_out=1 and done 5 RUN cycles after the match; match_count=1.
- Config error and abort:
  - start with len=0 -> err_cfg pulse, busy stays 0.
  - start with len=9 (MAX_LEN=8) -> err_cfg pulse, busy stays 0.
  - Valid start, abort together with the completing bit -> no match, no done, IDLE.
- Reset mid-run: drop rst_n during RUN with match_count=2 -> outputs 0 immediately. A new start after release runs from count 0.
